// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD bus timer.
// Default timings assume a 50 MHz clock.
package lcd_pkg;

  typedef enum logic [2:0] {
    LCD_PWRUP = 3'd0,
    LCD_IDLE  = 3'd1,
    LCD_SETUP = 3'd2,
    LCD_PULSE = 3'd3,
    LCD_HOLD  = 3'd4,
    LCD_EXEC  = 3'd5
  } lcd_bus_state_t;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  localparam int unsigned LCD_T_PWRUP_DEF     = 750000;
  localparam int unsigned LCD_T_SETUP_DEF     = 2;
  localparam int unsigned LCD_T_PULSE_DEF     = 12;
  localparam int unsigned LCD_T_HOLD_DEF      = 2;
  localparam int unsigned LCD_T_EXEC_DEF      = 2000;
  localparam int unsigned LCD_T_EXEC_LONG_DEF = 82000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Clear (0x01) and home (0x02/0x03) share an all-zero upper field; an
  // instruction byte of 0x00 is also given the long wait as the safe choice.
  function automatic logic is_long_exec(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == LCD_CMD_CLEAR[7:2]) && (data[7:2] == LCD_CMD_HOME[7:2]);
  endfunction

endpackage

// File: rtl/lcd_bus_timer_if.sv
// Byte-write request channel from the LCD sequencer into the bus timer.
// valid/ready: a byte transfers on a rising clk edge where req_valid && req_ready; req_rs/req_data matter only then.
interface lcd_bus_timer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;

  modport master (output req_valid, output req_rs, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_rs, input  req_data, output req_ready);
endinterface

// File: rtl/lcd_bus_timer.sv
// Drives HD44780 parallel pins for one byte write at a time, enforcing power-up,
// E setup/pulse/hold and command execution waits with one shared down-counter.
module lcd_bus_timer
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP     = LCD_T_PWRUP_DEF,
  parameter int unsigned T_SETUP     = LCD_T_SETUP_DEF,
  parameter int unsigned T_PULSE     = LCD_T_PULSE_DEF,
  parameter int unsigned T_HOLD      = LCD_T_HOLD_DEF,
  parameter int unsigned T_EXEC      = LCD_T_EXEC_DEF,
  parameter int unsigned T_EXEC_LONG = LCD_T_EXEC_LONG_DEF
) (
  input  logic           clk,
  input  logic           rst,
  lcd_bus_timer_if.slave req,
  output logic [7:0]     lcd_data,
  output logic           lcd_rs,
  output logic           lcd_rw,
  output logic           lcd_e,
  output logic           busy,
  output lcd_bus_state_t state_dbg
);

  localparam int unsigned T_MAX = max_u(max_u(max_u(T_PWRUP, T_SETUP), max_u(T_PULSE, T_HOLD)),
                                        max_u(T_EXEC, T_EXEC_LONG));
  localparam int CNT_W = $clog2(T_MAX + 1);

  // Reload values: a state lasting T cycles starts at T-1 and leaves on 0.
  localparam logic [CNT_W-1:0] C_PWRUP     = CNT_W'(T_PWRUP - 1);
  localparam logic [CNT_W-1:0] C_SETUP     = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] C_PULSE     = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] C_HOLD      = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] C_EXEC      = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] C_EXEC_LONG = CNT_W'(T_EXEC_LONG - 1);

  lcd_bus_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             ready_q;
  logic             busy_q;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= LCD_PWRUP;
      cnt      <= C_PWRUP;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      case (state)
        LCD_PWRUP: begin
          if (cnt_zero) begin
            state   <= LCD_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        LCD_IDLE: begin
          if (req.req_valid) begin
            state    <= LCD_SETUP;
            cnt      <= C_SETUP;
            lcd_rs   <= req.req_rs;
            lcd_data <= req.req_data;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        LCD_SETUP: begin
          if (cnt_zero) begin
            state <= LCD_PULSE;
            cnt   <= C_PULSE;
            lcd_e <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        LCD_PULSE: begin
          if (cnt_zero) begin
            state <= LCD_HOLD;
            cnt   <= C_HOLD;
            lcd_e <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        LCD_HOLD: begin
          if (cnt_zero) begin
            state <= LCD_EXEC;
            cnt   <= is_long_exec(lcd_rs, lcd_data) ? C_EXEC_LONG : C_EXEC;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        LCD_EXEC: begin
          // Counter is left at zero and simply held while idle.
          if (cnt_zero) begin
            state   <= LCD_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= LCD_PWRUP;
          cnt     <= C_PWRUP;
          lcd_e   <= 1'b0;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign req.req_ready = ready_q;
  assign busy          = busy_q;
  assign lcd_rw        = 1'b0;
  assign state_dbg     = state;

endmodule
